// File: rtl/rfphoenix_mt_insn_fifo.sv
// Multi-thread instruction FIFO: one circular queue per thread in a shared array.
// Optional same-cycle empty-thread bypass: define RFPHOENIX_IFIFO_BYPASS_EN.
module rfphoenix_mt_insn_fifo #(
  parameter int WID      = 128,
  parameter int DEP      = 16,
  parameter int NTHREADS = 4,
  parameter int AFULL    = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wr,
  input  logic [$clog2(NTHREADS)-1:0]             wr_thread,
  input  logic [WID-1:0]                          din,
  input  logic                                    rd,
  input  logic [$clog2(NTHREADS)-1:0]             rd_thread,
  output logic [WID-1:0]                          dout,
  input  logic [NTHREADS-1:0]                     flush,
  output logic [NTHREADS*($clog2(DEP)+1)-1:0]     cnt,
  output logic [NTHREADS-1:0]                     empty,
  output logic [NTHREADS-1:0]                     v,
  output logic [NTHREADS-1:0]                     full,
  output logic [NTHREADS-1:0]                     almost_full,
  output logic [NTHREADS-1:0]                     ovf,
  output logic [NTHREADS-1:0]                     unf,
  input  logic                                    err_clr
);

  localparam int PW = $clog2(DEP);
  localparam int TW = $clog2(NTHREADS);
  localparam int CW = PW + 1;
  localparam int AW = TW + PW;

  logic [WID-1:0]         mem [NTHREADS*DEP];
  logic [NTHREADS*PW-1:0] wr_ptr_all;
  logic [NTHREADS*PW-1:0] rd_ptr_all;
  logic [NTHREADS-1:0]    wr_sel;
  logic [NTHREADS-1:0]    rd_sel;
  logic [NTHREADS-1:0]    store_vec;
  logic [NTHREADS-1:0]    byp_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NTHREADS; gi++) begin : g_thread
      logic [PW-1:0] wr_ptr_reg;
      logic [PW-1:0] rd_ptr_reg;
      logic [CW-1:0] cnt_reg;
      logic          ovf_reg;
      logic          unf_reg;
      logic          rd_ok;
      logic          wr_ok;
      logic          byp;
      logic          inc;
      logic          dec;
      logic          ovf_set;
      logic          unf_set;

      assign wr_sel[gi] = wr && (wr_thread == TW'(gi));
      assign rd_sel[gi] = rd && (rd_thread == TW'(gi));

      assign empty[gi]       = (cnt_reg == '0);
      assign v[gi]           = ~empty[gi];
      assign full[gi]        = (cnt_reg == CW'(DEP));
      assign almost_full[gi] = (cnt_reg >= CW'(DEP - AFULL));

`ifdef RFPHOENIX_IFIFO_BYPASS_EN
      assign byp = wr_sel[gi] & rd_sel[gi] & empty[gi] & ~flush[gi];
`else
      assign byp = 1'b0;
`endif

      // A read on a full thread frees the slot the write lands in.
      assign rd_ok   = rd_sel[gi] & ~empty[gi];
      assign wr_ok   = wr_sel[gi] & (~full[gi] | rd_ok);
      assign inc     = wr_ok & ~flush[gi] & ~byp;
      assign dec     = rd_ok & ~flush[gi];
      assign ovf_set = wr_sel[gi] & full[gi] & ~rd_ok & ~flush[gi];
      assign unf_set = rd_sel[gi] & empty[gi] & ~flush[gi] & ~byp;

      assign store_vec[gi] = inc;
      assign byp_vec[gi]   = byp;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          cnt_reg    <= '0;
          ovf_reg    <= 1'b0;
          unf_reg    <= 1'b0;
        end else begin
          if (flush[gi]) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
          end else begin
            if (inc) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (dec) rd_ptr_reg <= rd_ptr_reg + PW'(1);
            cnt_reg <= cnt_reg + CW'(inc) - CW'(dec);
          end
          // A new error event outranks a simultaneous clear.
          ovf_reg <= ovf_set | (ovf_reg & ~err_clr);
          unf_reg <= unf_set | (unf_reg & ~err_clr);
        end
      end

      assign wr_ptr_all[gi*PW +: PW] = wr_ptr_reg;
      assign rd_ptr_all[gi*PW +: PW] = rd_ptr_reg;
      assign cnt[gi*CW +: CW]        = cnt_reg;
      assign ovf[gi]                 = ovf_reg;
      assign unf[gi]                 = unf_reg;
    end
  endgenerate

  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  assign wr_addr = {wr_thread, wr_ptr_all[wr_thread*PW +: PW]};
  assign rd_addr = {rd_thread, rd_ptr_all[rd_thread*PW +: PW]};

  // Storage is deliberately not reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (store_vec[wr_thread]) mem[wr_addr] <= din;
  end

  always_comb begin
    dout = '0;
    if (v[rd_thread])
      dout = mem[rd_addr];
    else if (byp_vec[rd_thread])
      dout = din;
  end

endmodule

// File: tb/tb_rfphoenix_mt_insn_fifo.sv
// Directed bench for rfphoenix_mt_insn_fifo (default parameters).
module tb_rfphoenix_mt_insn_fifo;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr;
  logic [1:0]   wr_thread;
  logic [127:0] din;
  logic         rd;
  logic [1:0]   rd_thread;
  logic [127:0] dout;
  logic [3:0]   flush;
  logic [19:0]  cnt;
  logic [3:0]   empty, v, full, almost_full, ovf, unf;
  logic         err_clr;

  int errors = 0;
  int checks = 0;

  rfphoenix_mt_insn_fifo dut (
    .clk(clk), .rst(rst), .wr(wr), .wr_thread(wr_thread), .din(din),
    .rd(rd), .rd_thread(rd_thread), .dout(dout), .flush(flush), .cnt(cnt),
    .empty(empty), .v(v), .full(full), .almost_full(almost_full),
    .ovf(ovf), .unf(unf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [4:0] cnt_of(input int t);
    return cnt[t*5 +: 5];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] t, input logic [127:0] d);
    wr = 1'b1; wr_thread = t; din = d;
    tick();
    wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; wr_thread = '0; din = '0; rd = 1'b0; rd_thread = '0;
    flush = '0; err_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_cnt", 128'(cnt), 128'h0);
    chk("rst_empty", 128'(empty), 128'hF);
    chk("rst_v", 128'(v), 128'h0);
    chk("rst_full", 128'(full), 128'h0);
    chk("rst_af", 128'(almost_full), 128'h0);
    chk("rst_ovf", 128'(ovf), 128'h0);
    chk("rst_unf", 128'(unf), 128'h0);
    chk("rst_dout", dout, 128'h0);

    // Fill thread 2: 0x11..0x1F, then 0x20 (16th), then 0x21 dropped.
    for (int i = 0; i < 15; i++) push(2'd2, 128'(8'h11 + i));
    chk("t2_cnt15", 128'(cnt_of(2)), 128'd15);
    chk("t2_af15", 128'(almost_full), 128'h4);
    chk("t2_notfull15", 128'(full), 128'h0);
    push(2'd2, 128'h20);
    chk("t2_full16", 128'(full), 128'h4);
    push(2'd2, 128'h21);
    chk("t2_ovf", 128'(ovf), 128'h4);
    chk("t2_cnt_stays16", 128'(cnt_of(2)), 128'd16);
    rd_thread = 2'd2;
    #1 chk("t2_head", dout, 128'h11);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("ovf_clr", 128'(ovf), 128'h0);

    // Read+write on full thread 2.
    rd = 1'b1; wr = 1'b1; wr_thread = 2'd2; din = 128'hAA;
    tick();
    rd = 1'b0; wr = 1'b0;
    chk("full_rw_cnt", 128'(cnt_of(2)), 128'd16);
    chk("full_rw_ovf", 128'(ovf), 128'h0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), dout, (i < 15) ? 128'(8'h12 + i) : 128'hAA);
      rd = 1'b1; tick(); rd = 1'b0;
    end
    chk("t2_empty", 128'(empty[2]), 128'h1);
    chk("t2_dout0", dout, 128'h0);

    // Interleave threads 0/3 while reading empty thread 1.
    rd = 1'b1; rd_thread = 2'd1;
    for (int i = 0; i < 3; i++) begin
      push(2'd0, 128'(8'hA0 + i));
      push(2'd3, 128'(8'hB0 + i));
    end
    chk("unf1", 128'(unf), 128'h2);
    err_clr = 1'b1; tick();
    chk("unf_clr_loses", 128'(unf), 128'h2);
    rd = 1'b0; tick(); err_clr = 1'b0;
    chk("unf_clr", 128'(unf), 128'h0);
    chk("t0_cnt3", 128'(cnt_of(0)), 128'd3);
    chk("t3_cnt3", 128'(cnt_of(3)), 128'd3);
    rd_thread = 2'd0; #1 chk("t0_head", dout, 128'hA0);
    rd_thread = 2'd3; #1 chk("t3_head", dout, 128'hB0);
    rd = 1'b1; tick(); rd = 1'b0;
    chk("t3_second", dout, 128'hB1);
    push(2'd3, 128'hB3);

    // Flush thread 0 with 5 entries and a simultaneous write.
    push(2'd0, 128'hA3); push(2'd0, 128'hA4);
    chk("t0_cnt5", 128'(cnt_of(0)), 128'd5);
    flush = 4'b0001; wr = 1'b1; wr_thread = 2'd0; din = 128'hEE;
    tick();
    flush = '0; wr = 1'b0;
    chk("flush_cnt0", 128'(cnt_of(0)), 128'd0);
    chk("flush_t3", 128'(cnt_of(3)), 128'd3);
    chk("flush_noovf", 128'(ovf), 128'h0);
    rd_thread = 2'd0; #1 chk("flush_dout", dout, 128'h0);

    // Same-cycle wr+rd on empty thread 1.
    rd_thread = 2'd1; rd = 1'b1; wr = 1'b1; wr_thread = 2'd1; din = 128'h55;
    #1;
`ifdef RFPHOENIX_IFIFO_BYPASS_EN
    chk("byp_dout", dout, 128'h55);
`else
    chk("byp_dout", dout, 128'h0);
`endif
    tick();
    rd = 1'b0; wr = 1'b0;
`ifdef RFPHOENIX_IFIFO_BYPASS_EN
    chk("byp_cnt", 128'(cnt_of(1)), 128'd0);
    chk("byp_unf", 128'(unf), 128'h0);
`else
    chk("byp_cnt", 128'(cnt_of(1)), 128'd1);
    chk("byp_unf", 128'(unf), 128'h2);
    chk("byp_stored", dout, 128'h55);
`endif
    flush = 4'b0010; err_clr = 1'b1; tick(); flush = '0; err_clr = 1'b0;

    // All threads at 8 entries, then asynchronous reset mid-cycle.
    for (int t = 0; t < 3; t++)
      for (int i = 0; i < 8; i++) push(2'(t), 128'(8'hC0 + i));
    for (int i = 0; i < 5; i++) push(2'd3, 128'(8'hD0 + i));
    chk("all8", 128'(cnt), 128'({4{5'd8}}));
    rd_thread = 2'd2;
    #2 rst = 1'b1;
    #1;
    chk("arst_cnt", 128'(cnt), 128'h0);
    chk("arst_empty", 128'(empty), 128'hF);
    chk("arst_dout", dout, 128'h0);
    tick();
    rst = 1'b0;
    push(2'd2, 128'h77);
    chk("post_rst_dout", dout, 128'h77);
    chk("post_rst_cnt", 128'(cnt_of(2)), 128'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rfphoenix_mt_insn_fifo.md
# rfphoenix_mt_insn_fifo

Multi-thread instruction FIFO between the decode stage and the issue/dispatch stage. Each hardware thread gets an independent circular queue of `DEP` entries, carried in one shared distributed-RAM array. Per-thread flush supports branch mispredict and exception recovery. A single enqueue port and a single dequeue port each select a thread per cycle; occupancy flags are presented per thread so the scheduler can pick a ready thread.

## Interface
- `WID`, 128: payload width in bits (decode bus plus fetch-buffer fields, concatenated by the instantiating module).
- `DEP`, 16: entries per thread; must be a power of two, ≥4.
- `NTHREADS`, 4: number of thread channels; power of two, ≥2.
- `AFULL`, 4: almost-full margin; `almost_full[t]` asserts when `cnt[t] >= DEP-AFULL`.

Ports:
- `clk`  in  1  clock, all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr`  in  1  enqueue strobe.
- `wr_thread`  in  $clog2(NTHREADS)  thread receiving `din`.
- `din`  in  WID  enqueue payload.
- `rd`  in  1  dequeue strobe.
- `rd_thread`  in  $clog2(NTHREADS)  thread being dequeued and shown on `dout`.
- `dout`  out  WID  head entry of `rd_thread` (combinational).
- `flush`  in  NTHREADS  per-thread flush request, one bit per thread.
- `cnt`  out  NTHREADS×($clog2(DEP)+1)  per-thread occupancy, 0..DEP.
- `empty`, `v`, `full`, `almost_full`  out  NTHREADS each  per-thread flags.
- `ovf`, `unf`  out  NTHREADS each  sticky overflow and underflow error flags.
- `err_clr`  in  1  clears all `ovf` and `unf` bits.

## Operation
- Storage is a `NTHREADS*DEP` entry array addressed as `{thread, ptr}`. Memory contents are not reset.
- Each thread has its own write pointer, read pointer and count. Pointers are `$clog2(DEP)` bits and wrap modulo `DEP`. The count is one bit wider, so all `DEP` entries are usable.
- Enqueue: `wr` with `full[wr_thread]`=0 writes `din` at the thread's write pointer, advances the pointer and adds 1 to the count.
  - `wr` with `full[wr_thread]`=1 is dropped: no storage or pointer change, and `ovf[wr_thread]` is set.
- Dequeue: `rd` with `empty[rd_thread]`=0 advances the thread's read pointer and subtracts 1 from the count.
  - `rd` on an empty thread is ignored and sets `unf[rd_thread]`. The bypass feature (see Configuration) modifies this case.
- Same thread enqueued and dequeued in one cycle:
  - Both take effect and the count is unchanged.
  - If the thread is full, this case is legal: the read frees the slot, so the write is accepted and `ovf` is not set.
- Different threads enqueued and dequeued in one cycle: the two operations are independent.
- Flush: `flush[t]`=1 zeroes thread t's pointers and count in that cycle. Flush has priority over `wr`/`rd` on the same thread; those operations are discarded without setting `ovf` or `unf`. Other threads are unaffected.
- Flag decoding per thread:
  - `empty` = (cnt==0)
  - `v` = ~`empty`
  - `full` = (cnt==DEP)
  - `almost_full` = (cnt >= DEP-AFULL)
- `dout`:
  - Equals the head entry of `rd_thread` when `v[rd_thread]`=1.
  - Equals all-zeros when `v[rd_thread]`=0. The bypass case below is the only exception.
- Error flags: `err_clr` clears `ovf`/`unf`. An error event in the same cycle as `err_clr` wins, so the flag stays 1.

## Timing
- Reset values: all pointers and counts 0, `empty`=all 1s, `v`/`full`/`almost_full`/`ovf`/`unf`=0, `dout`=0.
- Flags are decoded combinationally from the registered counts, so they change in the cycle after the edge that updates the count.
- Write-to-read latency is 1 cycle: an entry written at edge N is visible on `dout` after edge N.
- `dout` follows `rd_thread` combinationally with no added latency.
- Assertion of `rst` mid-operation clears the state immediately, without waiting for a clock edge. Entries in flight are lost.

## Configuration
- `RFPHOENIX_IFIFO_BYPASS_EN`
  - Defined: when `wr` and `rd` target the same thread, that thread is empty, and `flush` is clear for it, `dout` = `din` combinationally. The entry is consumed, not stored, and the count stays 0. `unf` is not set.
  - Undefined: that case stores `din`, sets `unf`, and `dout` is 0 during that cycle.

## Test plan
- Reset, then write 0x11..0x1F (15 entries) to thread 2 → `cnt[2]`=15, `almost_full[2]`=1, `full[2]`=0; 16th write gives `full[2]`=1; 17th write sets `ovf[2]`=1 and `cnt[2]` stays 16.
- Thread 2 full, then `rd`+`wr` to thread 2 with `din`=0xAA → `cnt` stays 16, no `ovf`; drain 16 entries in order ending with 0xAA; then `empty[2]`=1 and `dout`=0.
- Interleave writes to threads 0 and 3 (0xA0.., 0xB0..) while reading thread 1, which is empty → per-thread ordering is kept, `unf[1]`=1, `err_clr` clears it.
- Thread 0 holds 5 entries; `flush[0]` with a simultaneous `wr` to thread 0 → `cnt[0]`=0, write discarded; thread 3's count is unaffected.
- With the macro defined, thread 1 empty, `wr`+`rd` to thread 1 with `din`=0x55 → `dout`=0x55 in the same cycle and `cnt[1]`=0; with the macro undefined → `cnt[1]`=1 and `unf[1]`=1.
- Assert `rst` between clock edges with all threads at 8 entries → all outputs reach their reset values before the next edge.
